ber_sync_checker: RTL and testbench
===================================

Name: ber_sync_checker

Overview:
Receive-side bit checker for one QPSK branch (I or Q). It consumes hard decisions from the slicer and the locally regenerated PRBS reference. It then searches the reference delay that aligns the two, locks on it, and accumulates bit and error counts for BER measurement. Two instances sit after the phase/slicer stage; counters are exported to the VIO.

Parameters:
NB_COUNT, 64, width of bit and error counters
NB_DELAY, 9, width of delay index; delay line length DELAY_LEN = 2**NB_DELAY (localparam, 512)
WIN_LEN, 1024, valid strobes per candidate search window
NB_WIN, 11, width of window/error-per-window counters (must hold WIN_LEN)

Ports:
clock  in  1  system clock
i_reset  in  1  synchronous reset, active-high
i_enable  in  1  global enable; low freezes all state
i_valid  in  1  baud strobe, one cycle per symbol
i_rx_bit  in  1  slicer decision
i_ref_bit  in  1  local PRBS bit
i_resync  in  1  pulse: discard lock, clear counters, restart fill/search
o_locked  out  1  alignment found, counting active
o_delay  out  NB_DELAY  selected delay (valid when o_locked)
o_exor  out  1  registered rx XOR delayed ref (LOCKED only, else 0)
o_bit_count  out  NB_COUNT  compared bits since lock
o_err_count  out  NB_COUNT  mismatches since lock

Behaviour:
- Reset: state FILL; every output 0; delay line, fill, window, min and best registers cleared (min_err set to all ones).
- "step" = i_enable & i_valid. Nothing changes when i_enable=0. i_valid between steps is ignored.
- Delay line: DELAY_LEN-bit shift register; on each step it shifts in i_ref_bit. ref_d = sr[cand] in SEARCH, sr[o_delay] in LOCKED. Tap 0 = newest bit.
- FSM:
  - FILL: count DELAY_LEN steps, then go to SEARCH with cand=0, win_cnt=0, win_err=0.
  - SEARCH: each step, win_err += i_rx_bit ^ ref_d and win_cnt++. At the last window step (win_cnt = WIN_LEN-1) the final error includes the current bit. If total < min_err (strict), then min_err <= total and best <= cand; ties keep the lower delay. Then cand++ and clear the window. After the window of cand = DELAY_LEN-1: o_delay <= best (or cand if that window is the new minimum), o_locked <= 1, go to LOCKED.
  - LOCKED: each step, o_exor <= i_rx_bit ^ ref_d; o_bit_count++; o_err_count += o_exor value. Both counters saturate at all ones and never wrap.
- Latency: o_exor and both counters update on the clock edge that samples the step, visible the next cycle. o_locked rises one cycle after the final search step.
- i_resync (enabled): next state FILL. Clears o_locked, o_delay, counters, o_exor, min/best, and the fill count. Delay line contents are kept. A simultaneous step is not counted. Resync has priority over the FSM.
- i_reset mid-search or mid-lock: same as power-up reset, which also clears the delay line.
- No loss-of-lock detection in base configuration.

Optional Feature:
BER_EARLY_LOCK_EN
- Defined: a SEARCH window ending with 0 errors locks immediately on that cand, without scanning the remaining delays.
- Undefined: the full scan of all DELAY_LEN candidates is always performed, and the minimum-error delay wins.

Decomposition:
- Package ber_pkg holds the FSM state enum (FILL, SEARCH, LOCKED) and the saturating-add width constant helpers.
- One natural sub-module, ber_sat_counter: NB-bit counter with enable, increment input and saturation. It is instantiated twice (bits, errors).

Test Plan:
- Reset, then i_ref_bit = PRBS9 and i_rx_bit = same sequence delayed 37 steps, with valid every 4 clocks. Expect o_locked=1 after 512 + 512·1024 steps, o_delay=37, and o_err_count=0 after 10000 further steps with o_bit_count=10000.
- Locked at delay 37, then invert every 100th rx bit for 10000 steps. Expect o_err_count=100 and an o_exor pulse on each inverted bit one cycle after its step.
- Preload counters near saturation (NB_COUNT=8 build) with rx fully inverted. Expect o_err_count to stick at 255 with no wrap.
- Locked state, then assert i_resync coincident with i_valid. Next cycle expect o_locked=0, counters 0, state FILL; that step is not counted, and relock occurs at the same delay.
- i_enable=0 for 500 clocks mid-SEARCH with valid toggling. Expect cand, window count and delay line unchanged; the search resumes exactly on re-enable.
- BER_EARLY_LOCK_EN defined, delay 3. Expect lock after 512 + 4·1024 steps with o_delay=3. Same stimulus without the macro: expect lock only after the full scan, o_delay=3.

Source files
------------

// File: rtl/ber_pkg.sv
// Shared types and helpers for the BER sync checker.
package ber_pkg;

  // Checker FSM: fill the reference delay line, scan candidate delays, then count.
  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } berState_t;

  // Saturation limit (all ones) of an nb-bit counter, nb <= 64.
  // For nb = 64 the shift yields zero and the subtraction wraps to all ones.
  function automatic logic [63:0] satMax(input int nb);
    return (64'd1 << nb) - 64'd1;
  endfunction

endpackage

// File: rtl/ber_sat_counter.sv
// Saturating up-counter: adds a 1-bit increment when enabled, sticks at all ones.
module ber_sat_counter
  import ber_pkg::*;
#(
  parameter int NB = 64
) (
  input  logic          clock,
  input  logic          i_reset,
  input  logic          i_clear,
  input  logic          i_enable,
  input  logic          i_inc,
  output logic [NB-1:0] o_count
);

  localparam logic [NB-1:0] MAX = NB'(satMax(NB));

  // Clear wins over counting; once the limit is reached the value never wraps.
  always_ff @(posedge clock) begin
    if (i_reset || i_clear) o_count <= '0;
    else if (i_enable && i_inc && (o_count != MAX)) o_count <= o_count + NB'(1);
  end

endmodule

// File: rtl/ber_sync_checker.sv
// Bit checker for one QPSK branch: aligns the local PRBS reference against
// slicer decisions by minimum errors over a window, locks, then counts bits
// and errors for BER. Optional macro BER_EARLY_LOCK_EN: lock as soon as a
// search window ends with zero errors instead of scanning every delay.
module ber_sync_checker
  import ber_pkg::*;
#(
  parameter int NB_COUNT = 64,
  parameter int NB_DELAY = 9,
  parameter int WIN_LEN  = 1024,
  parameter int NB_WIN   = 11
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_valid,
  input  logic                i_rx_bit,
  input  logic                i_ref_bit,
  input  logic                i_resync,
  output logic                o_locked,
  output logic [NB_DELAY-1:0] o_delay,
  output logic                o_exor,
  output logic [NB_COUNT-1:0] o_bit_count,
  output logic [NB_COUNT-1:0] o_err_count
);

  localparam int DELAY_LEN = 2 ** NB_DELAY;
  localparam logic [NB_WIN-1:0] WIN_LAST = NB_WIN'(WIN_LEN - 1);

  berState_t             state;
  // Tap 0 is the bit arriving on this step, so only DELAY_LEN-1 bits are stored.
  logic [DELAY_LEN-2:0]  sr;
  logic [DELAY_LEN-1:0]  srNext;
  logic [NB_DELAY-1:0]   fillCnt;
  logic [NB_DELAY-1:0]   cand;
  logic [NB_DELAY-1:0]   best;
  logic [NB_WIN-1:0]     winCnt;
  logic [NB_WIN-1:0]     winErr;
  logic [NB_WIN-1:0]     minErr;
  logic [NB_WIN-1:0]     winTotal;
  logic                  refD;
  logic                  xorBit;
  logic                  step;
  logic                  countEn;
  logic                  clearCnt;

  assign step     = i_enable & i_valid;
  assign srNext   = {sr, i_ref_bit};
  assign refD     = srNext[(state == LOCKED) ? o_delay : cand];
  assign xorBit   = i_rx_bit ^ refD;
  assign winTotal = winErr + NB_WIN'(xorBit);
  assign clearCnt = i_enable & i_resync;
  assign countEn  = step & ~i_resync & (state == LOCKED);

  // Delay line, fill/search bookkeeping and registered outputs.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state    <= FILL;
      sr       <= '0;
      fillCnt  <= '0;
      cand     <= '0;
      best     <= '0;
      winCnt   <= '0;
      winErr   <= '0;
      minErr   <= '1;
      o_locked <= 1'b0;
      o_delay  <= '0;
      o_exor   <= 1'b0;
    end else if (i_enable) begin
      if (i_resync) begin
        // Restart alignment; the delay line keeps its history.
        state    <= FILL;
        fillCnt  <= '0;
        cand     <= '0;
        best     <= '0;
        winCnt   <= '0;
        winErr   <= '0;
        minErr   <= '1;
        o_locked <= 1'b0;
        o_delay  <= '0;
        o_exor   <= 1'b0;
      end else begin
        // o_exor is a one-cycle pulse per compared bit.
        o_exor <= 1'b0;
        if (i_valid) begin
          sr <= srNext[DELAY_LEN-2:0];
          case (state)
            FILL: begin
              fillCnt <= fillCnt + NB_DELAY'(1);
              if (&fillCnt) begin
                state  <= SEARCH;
                cand   <= '0;
                winCnt <= '0;
                winErr <= '0;
              end
            end
            SEARCH: begin
              if (winCnt == WIN_LAST) begin
                winCnt <= '0;
                winErr <= '0;
                // Strict compare: on a tie the earlier (lower) delay is kept.
                if (winTotal < minErr) begin
                  minErr <= winTotal;
                  best   <= cand;
                end
`ifdef BER_EARLY_LOCK_EN
                if (winTotal == '0) begin
                  o_delay  <= cand;
                  o_locked <= 1'b1;
                  state    <= LOCKED;
                end else
`endif
                if (&cand) begin
                  o_delay  <= (winTotal < minErr) ? cand : best;
                  o_locked <= 1'b1;
                  state    <= LOCKED;
                end else begin
                  cand <= cand + NB_DELAY'(1);
                end
              end else begin
                winCnt <= winCnt + NB_WIN'(1);
                winErr <= winTotal;
              end
            end
            LOCKED: o_exor <= xorBit;
            default: state <= FILL;
          endcase
        end
      end
    end
  end

  ber_sat_counter #(.NB(NB_COUNT)) uBitCnt (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_clear  (clearCnt),
    .i_enable (countEn),
    .i_inc    (1'b1),
    .o_count  (o_bit_count)
  );

  ber_sat_counter #(.NB(NB_COUNT)) uErrCnt (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_clear  (clearCnt),
    .i_enable (countEn),
    .i_inc    (xorBit),
    .o_count  (o_err_count)
  );

endmodule

// File: tb/tb_ber_sync_checker.sv
// Self-checking bench for ber_sync_checker, built with reduced sizes so a
// full delay scan stays short. Reference is PRBS9; rx is the reference
// delayed by dly steps with selectable bit inversions.
module tb_ber_sync_checker;

  localparam int NB_COUNT = 8;
  localparam int NB_DELAY = 6;
  localparam int WIN_LEN  = 32;
  localparam int NB_WIN   = 6;
  localparam int DLEN     = 2 ** NB_DELAY;

  logic                clock = 1'b0;
  logic                i_reset, i_enable, i_valid, i_rx_bit, i_ref_bit, i_resync;
  logic                o_locked, o_exor;
  logic [NB_DELAY-1:0] o_delay;
  logic [NB_COUNT-1:0] o_bit_count, o_err_count;

  ber_sync_checker #(
    .NB_COUNT(NB_COUNT), .NB_DELAY(NB_DELAY), .WIN_LEN(WIN_LEN), .NB_WIN(NB_WIN)
  ) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_valid     (i_valid),
    .i_rx_bit    (i_rx_bit),
    .i_ref_bit   (i_ref_bit),
    .i_resync    (i_resync),
    .o_locked    (o_locked),
    .o_delay     (o_delay),
    .o_exor      (o_exor),
    .o_bit_count (o_bit_count),
    .o_err_count (o_err_count)
  );

  always #5 clock = ~clock;

  int       nCmp = 0;
  int       nErr = 0;
  bit       refHist [0:65535];
  int       idx = 0;
  int       dly = 37;
  logic [8:0] lfsr = 9'h1FF;
  bit       expQ [$];

  typedef struct {
    int nSteps;
    int invEvery;
    int gap;
    bit freeze;
    int expBits;
    int expErrs;
  } seg_t;
  seg_t segs [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Steps needed from FILL to lock with the true delay d.
  function automatic int lockSteps(input int d);
`ifdef BER_EARLY_LOCK_EN
    return DLEN + (d + 1) * WIN_LEN;
`else
    return DLEN + DLEN * WIN_LEN + 0 * d;
`endif
  endfunction

  // One baud step followed by gap-1 idle clocks; sb enables o_exor scoreboarding.
  task automatic step(input bit inv, input int gap, input bit sb);
    bit b, r;
    b = lfsr[8] ^ lfsr[4];
    lfsr = {lfsr[7:0], b};
    refHist[idx] = b;
    r = (idx >= dly) ? refHist[idx - dly] : 1'b0;
    i_ref_bit = b;
    i_rx_bit  = r ^ inv;
    i_valid   = 1'b1;
    idx++;
    if (sb) expQ.push_back(inv);
    tick;
    i_valid   = 1'b0;
    i_rx_bit  = 1'($urandom);
    i_ref_bit = 1'($urandom);
    if (sb) chk("exor_step", {63'd0, o_exor}, {63'd0, expQ.pop_front()});
    for (int g = 1; g < gap; g++) begin
      tick;
      if (sb) chk("exor_idle", {63'd0, o_exor}, 64'd0);
    end
  endtask

  // Drive aligned steps until lock; optionally freeze enable mid-search.
  task automatic runLock(input int nSteps, input int gap, input int expDly,
                         input int freezeAt, input string tag);
    for (int s = 1; s <= nSteps; s++) begin
      step(1'b0, gap, 1'b0);
      if (s == freezeAt) begin
        i_enable = 1'b0;
        for (int c = 0; c < 500; c++) begin
          i_valid   = c[0];
          i_resync  = (c % 97 == 5);
          i_rx_bit  = 1'($urandom);
          i_ref_bit = 1'($urandom);
          tick;
        end
        i_valid  = 1'b0;
        i_resync = 1'b0;
        i_enable = 1'b1;
        chk({tag, "_frz_locked"}, {63'd0, o_locked}, 64'd0);
      end
      if (s == nSteps - 1) chk({tag, "_notyet"}, {63'd0, o_locked}, 64'd0);
    end
    chk({tag, "_locked"}, {63'd0, o_locked}, 64'd1);
    chk({tag, "_delay"}, 64'(o_delay), 64'(expDly));
  endtask

  initial begin
    segs[0] = '{nSteps: 200, invEvery: 0,  gap: 4, freeze: 1'b0, expBits: 200, expErrs: 0};
    segs[1] = '{nSteps: 200, invEvery: 20, gap: 1, freeze: 1'b1, expBits: 200, expErrs: 10};
    segs[2] = '{nSteps: 300, invEvery: 1,  gap: 1, freeze: 1'b0, expBits: 255, expErrs: 255};
    segs[3] = '{nSteps: 250, invEvery: 50, gap: 2, freeze: 1'b0, expBits: 250, expErrs: 5};

    i_reset = 1'b1; i_enable = 1'b1; i_valid = 1'b0;
    i_rx_bit = 1'b0; i_ref_bit = 1'b0; i_resync = 1'b0;
    repeat (3) tick;
    chk("rst_locked", {63'd0, o_locked}, 64'd0);
    chk("rst_delay",  64'(o_delay), 64'd0);
    chk("rst_exor",   {63'd0, o_exor}, 64'd0);
    chk("rst_bits",   64'(o_bit_count), 64'd0);
    chk("rst_errs",   64'(o_err_count), 64'd0);
    i_reset = 1'b0;

    // First lock: sparse strobes, enable frozen for 500 clocks mid-search.
    runLock(lockSteps(37), 4, 37, 1000, "lock37");

    for (int k = 0; k < 4; k++) begin
      chk("seg_bits0", 64'(o_bit_count), 64'd0);
      chk("seg_errs0", 64'(o_err_count), 64'd0);
      for (int s = 1; s <= segs[k].nSteps; s++) begin
        step((segs[k].invEvery != 0) ? (s % segs[k].invEvery == 0) : 1'b0, segs[k].gap, 1'b1);
        if (segs[k].freeze && s == 100) begin
          i_enable = 1'b0;
          i_valid  = 1'b1;
          for (int c = 0; c < 50; c++) begin
            i_rx_bit = 1'($urandom);
            tick;
          end
          i_valid  = 1'b0;
          i_enable = 1'b1;
          chk("frz_bits", 64'(o_bit_count), 64'd100);
          chk("frz_errs", 64'(o_err_count), 64'd5);
        end
      end
      chk("seg_bits", 64'(o_bit_count), 64'(segs[k].expBits));
      chk("seg_errs", 64'(o_err_count), 64'(segs[k].expErrs));

      // Resync coincident with a strobe: that step must not be counted.
      i_resync  = 1'b1;
      i_valid   = 1'b1;
      i_rx_bit  = 1'b1;
      i_ref_bit = 1'b0;
      tick;
      i_resync = 1'b0;
      i_valid  = 1'b0;
      chk("rsy_locked", {63'd0, o_locked}, 64'd0);
      chk("rsy_delay",  64'(o_delay), 64'd0);
      chk("rsy_exor",   {63'd0, o_exor}, 64'd0);
      chk("rsy_bits",   64'(o_bit_count), 64'd0);
      chk("rsy_errs",   64'(o_err_count), 64'd0);
      runLock(lockSteps(37), 1, 37, 0, "relock");
    end

    // Power-up style reset, then a short delay.
    i_reset = 1'b1;
    tick;
    i_reset = 1'b0;
    chk("rst2_locked", {63'd0, o_locked}, 64'd0);
    chk("rst2_bits",   64'(o_bit_count), 64'd0);
    dly = 3;
    runLock(lockSteps(3), 1, 3, 0, "lock3");
    for (int s = 1; s <= 40; s++) step(s % 8 == 0, 1, 1'b1);
    chk("d3_bits", 64'(o_bit_count), 64'd40);
    chk("d3_errs", 64'(o_err_count), 64'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
